// File: rtl/rng_request_arbiter_if.sv
// Signal bundle between the entropy arbiter, its consumers and the serial entropy source.
interface rng_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
);
  logic [NUM_REQ-1:0] req;
  logic               ent_bit;
  logic               ent_valid;
  logic               ent_en;
  logic [NUM_REQ-1:0] rnd_valid;
  logic [WIDTH-1:0]   rnd_data;
  logic               busy;
  logic               health_fail;

  modport slave (
    input  req, ent_bit, ent_valid,
    output ent_en, rnd_valid, rnd_data, busy, health_fail
  );

  modport master (
    output req, ent_bit, ent_valid,
    input  ent_en, rnd_valid, rnd_data, busy, health_fail
  );
endinterface

// File: rtl/rng_request_arbiter.sv
// Round-robin sharing of one serial entropy source between NUM_REQ consumers, WIDTH bits per grant.
// Optional repetition-count health test enabled by defining RNG_HEALTH_EN.
module rng_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 128,
  parameter int RUN_LIMIT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rng_request_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
  logic [NUM_REQ-1:0] rnd_valid_q, rnd_valid_d;
  logic               ent_en_q, ent_en_d;
  logic               busy_q, busy_d;
  logic               arb_hit_s;
  logic [GW-1:0]      arb_idx_s;
  logic [GW-1:0]      cand_s;
  logic               health_trip_s;
  logic               lock_s;

  // Round-robin pick: first active request after the last requester that was served.
  always_comb begin
    arb_hit_s = 1'b0;
    arb_idx_s = '0;
    cand_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!arb_hit_s && bus.req[cand_s]) begin
        arb_hit_s = 1'b1;
        arb_idx_s = cand_s;
      end else begin
        arb_hit_s = arb_hit_s;
      end
    end
  end

  // Next-state and datapath for the IDLE -> COLLECT -> DELIVER cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    shift_d      = shift_q;
    rnd_data_d   = rnd_data_q;
    rnd_valid_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_hit_s && !lock_s) begin
          grant_d = arb_idx_s;
          count_d = '0;
          shift_d = '0;
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        // A withdrawn request or a failed source drops the partial word.
        if (!bus.req[grant_q] || health_trip_s) begin
          count_d = '0;
          shift_d = '0;
          state_d = S_IDLE;
        end else if (bus.ent_valid) begin
          shift_d = {shift_q[WIDTH-2:0], bus.ent_bit};
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = S_DELIVER;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DELIVER: begin
        rnd_data_d   = shift_q;
        rnd_valid_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
        last_grant_d = grant_q;
        shift_d      = '0;
        count_d      = '0;
        state_d      = S_IDLE;
      end
      default: begin
        count_d = '0;
        shift_d = '0;
        state_d = S_IDLE;
      end
    endcase
    ent_en_d = (state_d == S_COLLECT);
    busy_d   = (state_d == S_COLLECT) || (state_d == S_DELIVER);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      count_q      <= '0;
      shift_q      <= '0;
      rnd_data_q   <= '0;
      rnd_valid_q  <= '0;
      ent_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      rnd_data_q   <= rnd_data_d;
      rnd_valid_q  <= rnd_valid_d;
      ent_en_q     <= ent_en_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ent_en    = ent_en_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_data  = rnd_data_q;
  assign bus.busy      = busy_q;

`ifdef RNG_HEALTH_EN
  localparam int RW = $clog2(RUN_LIMIT + 1);

  logic [RW-1:0] run_q, run_d, run_next_s;
  logic          last_bit_q, last_bit_d;
  logic          health_fail_q, health_fail_d;

  // Repetition-count test on every bit accepted while collecting.
  always_comb begin
    run_d         = run_q;
    last_bit_d    = last_bit_q;
    health_fail_d = health_fail_q;
    health_trip_s = 1'b0;
    run_next_s    = ((run_q != '0) && (bus.ent_bit == last_bit_q)) ? run_q + RW'(1) : RW'(1);
    if (state_q == S_IDLE) begin
      run_d = '0;
    end else if ((state_q == S_COLLECT) && bus.ent_valid) begin
      run_d      = run_next_s;
      last_bit_d = bus.ent_bit;
      if (run_next_s == RW'(RUN_LIMIT)) begin
        health_trip_s = 1'b1;
        health_fail_d = 1'b1;
      end else begin
        health_trip_s = 1'b0;
      end
    end else begin
      run_d = run_q;
    end
  end

  // Health registers; the failure flag only clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q         <= '0;
      last_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      last_bit_q    <= last_bit_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign lock_s          = health_fail_q;
  assign bus.health_fail = health_fail_q;
`else
  assign health_trip_s   = 1'b0;
  assign lock_s          = 1'b0;
  // RUN_LIMIT is never negative, so this is a constant 0 without the health test.
  assign bus.health_fail = (RUN_LIMIT < 0);
`endif

endmodule
